// File: rtl/map_scan_seq_if.sv
// Bus bundle for map_scan_seq: scan request/configuration, the three
// x/y/plane token streams, and status outputs.
interface map_scan_seq_if;
  logic        start;
  logic [15:0] cfg_w;
  logic [15:0] cfg_h;
  logic [15:0] cfg_p;

  logic        out1_send;
  logic        out2_send;
  logic        out3_send;
  logic [15:0] out1_data;
  logic [15:0] out2_data;
  logic [15:0] out3_data;
  logic [15:0] out1_count;
  logic [15:0] out2_count;
  logic [15:0] out3_count;
  logic        out1_rdy;
  logic        out2_rdy;
  logic        out3_rdy;
  logic        out1_ack;
  logic        out2_ack;
  logic        out3_ack;

  logic        busy;
  logic        done;
  logic [31:0] tokens;

  // Requester / downstream side
  modport master (
    output start, cfg_w, cfg_h, cfg_p,
    output out1_rdy, out2_rdy, out3_rdy,
    output out1_ack, out2_ack, out3_ack,
    input  out1_send, out2_send, out3_send,
    input  out1_data, out2_data, out3_data,
    input  out1_count, out2_count, out3_count,
    input  busy, done, tokens
  );

  // Scan generator side
  modport slave (
    input  start, cfg_w, cfg_h, cfg_p,
    input  out1_rdy, out2_rdy, out3_rdy,
    input  out1_ack, out2_ack, out3_ack,
    output out1_send, out2_send, out3_send,
    output out1_data, out2_data, out3_data,
    output out1_count, out2_count, out3_count,
    output busy, done, tokens
  );
endinterface

// File: rtl/map_scan_seq.sv
// Raster scan sequencer: walks x, then y, then plane over a latched
// W x H x P extent, emitting one (x,y,p) tuple per cycle on three lock-step
// token streams whenever all downstream consumers are ready.
module map_scan_seq (
  input  logic          clk,
  input  logic          reset,
  map_scan_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] x_reg;
  logic [15:0] y_reg;
  logic [15:0] p_reg;
  logic [15:0] cfg_w_reg;
  logic [15:0] cfg_h_reg;
  logic [15:0] cfg_p_reg;
  logic [31:0] tokens_reg;

  logic        fire;
  logic        cfg_zero;
  logic        x_last;
  logic        y_last;
  logic        p_last;
  logic        last_tuple;

  logic        send;
  logic [15:0] x_out;
  logic [15:0] y_out;
  logic [15:0] p_out;
  logic        busy;
  logic        done;

  // Acknowledges carry no meaning for this block.
  logic        unused_ack;
  assign unused_ack = bus.out1_ack ^ bus.out2_ack ^ bus.out3_ack;

  // A transfer happens only when every stream can take its token; reset
  // blocks it so nothing leaves the block in a reset cycle.
  assign fire       = bus.out1_rdy & bus.out2_rdy & bus.out3_rdy & ~reset;
  assign cfg_zero   = (bus.cfg_w == 16'd0) | (bus.cfg_h == 16'd0) | (bus.cfg_p == 16'd0);
  assign x_last     = (x_reg == cfg_w_reg - 16'd1);
  assign y_last     = (y_reg == cfg_h_reg - 16'd1);
  assign p_last     = (p_reg == cfg_p_reg - 16'd1);
  assign last_tuple = x_last & y_last & p_last;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = cfg_zero ? FIN : RUN;
        end
      end
      RUN: begin
        if (fire && last_tuple) begin
          state_next = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Configuration latch, raster counters and saturating tuple count
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg      <= 16'd0;
      y_reg      <= 16'd0;
      p_reg      <= 16'd0;
      cfg_w_reg  <= 16'd0;
      cfg_h_reg  <= 16'd0;
      cfg_p_reg  <= 16'd0;
      tokens_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cfg_w_reg  <= bus.cfg_w;
            cfg_h_reg  <= bus.cfg_h;
            cfg_p_reg  <= bus.cfg_p;
            x_reg      <= 16'd0;
            y_reg      <= 16'd0;
            p_reg      <= 16'd0;
            tokens_reg <= 32'd0;
          end
        end
        RUN: begin
          if (fire) begin
            if (tokens_reg != 32'hFFFF_FFFF) begin
              tokens_reg <= tokens_reg + 32'd1;
            end
            // The final tuple leaves the counters parked on the last index.
            if (!last_tuple) begin
              if (!x_last) begin
                x_reg <= x_reg + 16'd1;
              end else begin
                x_reg <= 16'd0;
                if (!y_last) begin
                  y_reg <= y_reg + 16'd1;
                end else begin
                  y_reg <= 16'd0;
                  p_reg <= p_reg + 16'd1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode; everything except COUNT is forced quiet during reset
  always_comb begin
    send  = 1'b0;
    x_out = 16'd0;
    y_out = 16'd0;
    p_out = 16'd0;
    busy  = 1'b0;
    done  = 1'b0;
    if (!reset) begin
      send  = (state_reg == RUN) & fire;
      x_out = x_reg;
      y_out = y_reg;
      p_out = p_reg;
      busy  = (state_reg == RUN);
      done  = (state_reg == FIN);
    end
  end

  assign bus.out1_send  = send;
  assign bus.out2_send  = send;
  assign bus.out3_send  = send;
  assign bus.out1_data  = x_out;
  assign bus.out2_data  = y_out;
  assign bus.out3_data  = p_out;
  assign bus.out1_count = 16'h0001;
  assign bus.out2_count = 16'h0001;
  assign bus.out3_count = 16'h0001;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.tokens     = tokens_reg;
endmodule

// File: doc/map_scan_seq.md
MAP_SCAN_SEQ -- requirements
Module: map_scan_seq

Interface
REQ-001: CLK  in  1  single clock; all state updates on rising edge.
REQ-002: RESET  in  1  synchronous, active-high reset.
REQ-003: START  in  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-004: CFG_W / CFG_H / CFG_P  in  16 each  scan extents (x width, y height, plane count); latched on accepted START.
REQ-005: Out1_SEND / Out2_SEND / Out3_SEND  out  1 each  token valid for the x / y / plane stream respectively.
REQ-006: Out1_DATA / Out2_DATA / Out3_DATA  out  16 each  current x / y / plane index.
REQ-007: Out1_COUNT / Out2_COUNT / Out3_COUNT  out  16 each  tokens in the transfer; constant 16'h1.
REQ-008: Out1_RDY / Out2_RDY / Out3_RDY  in  1 each  downstream can accept a token this cycle.
REQ-009: Out1_ACK / Out2_ACK / Out3_ACK  in  1 each  downstream acknowledge; ignored by this block.
REQ-010: BUSY  out  1  high in RUN state.
REQ-011: DONE  out  1  one-cycle pulse at scan completion.
REQ-012: TOKENS  out  32  number of tuples emitted since last accepted START.

Function
REQ-013: The block SHALL implement FSM states IDLE, RUN, FIN; encoding is free.
REQ-014: IDLE SHALL move to RUN on START=1 while all of CFG_W, CFG_H, CFG_P are nonzero; the block latches the configuration, clears x, y, p and TOKENS.
REQ-015: IDLE SHALL move directly to FIN on START=1 when any CFG extent is zero; no tokens are emitted and TOKENS is cleared.
REQ-016: START SHALL be ignored in RUN and FIN; the configuration SHALL be taken only from the latched registers during RUN.
REQ-017: In RUN, define fire = Out1_RDY & Out2_RDY & Out3_RDY & ~RESET.
REQ-018: Out1_SEND, Out2_SEND and Out3_SEND SHALL all equal (state==RUN) & fire, combinationally in the same cycle; the three streams never emit independently.
REQ-019: Out1_DATA, Out2_DATA and Out3_DATA SHALL present the registered x, y and p respectively; each is zero-extended to 16 bits.
REQ-020: On fire, the counters SHALL advance in raster order: x increments; at x=W-1, x wraps to 0 and y increments; at y=H-1, y wraps to 0 and p increments.
REQ-021: On fire with x=W-1, y=H-1 and p=P-1 (the last tuple), the FSM SHALL move to FIN and x, y, p SHALL hold.
REQ-022: With no fire in RUN, the state, counters and TOKENS SHALL hold; stalls of any length are lossless.
REQ-023: TOKENS SHALL increment by 1 on every fire and SHALL saturate at 32'hFFFFFFFF.
REQ-024: FIN SHALL assert DONE for exactly one cycle and SHALL return to IDLE on the next edge.
REQ-025: The first tuple SHALL be available in the cycle after START is accepted; throughput SHALL be 1 tuple/cycle while all RDY inputs are high.
REQ-026: Total tuples per scan SHALL be W*H*P; the full 16-bit extent range up to 65535 is legal.

Reset
REQ-027: With RESET=1 at a clock edge, the block SHALL go to IDLE and clear x, y, p, TOKENS and the latched configuration.
REQ-028: During reset, every SEND output, BUSY and DONE SHALL be 0; DATA outputs SHALL be 0 and COUNT outputs SHALL be 16'h1.
REQ-029: In a cycle where RESET=1, no SEND SHALL be asserted, including mid-scan; no DONE pulse SHALL follow a reset-aborted scan.

Verification
REQ-030: Basic scan.
- Stimulus: W=2, H=2, P=1; all RDY=1; START pulse.
- Response: tuples (0,0,0), (1,0,0), (0,1,0), (1,1,0) on 4 consecutive cycles starting the cycle after START.
- Response: DONE pulses the following cycle; TOKENS=4; BUSY high for exactly 4 cycles.
REQ-031: Backpressure stall.
- Stimulus: W=3, H=1, P=2; Out2_RDY=0 for 5 cycles after the 2nd tuple.
- Response: no SEND on any stream during the stall; the tuple sequence resumes at (2,0,0) with none lost or duplicated; 6 tuples total.
REQ-032: Zero extent.
- Stimulus: START with CFG_H=0.
- Response: no SEND; DONE one cycle after START; TOKENS=0; BUSY never high.
REQ-033: START during RUN.
- Stimulus: W=4, H=1, P=1 running; START pulsed with W=1 while BUSY.
- Response: the scan still emits 4 tuples; DONE pulses once.
REQ-034: Mid-scan reset.
- Stimulus: RESET=1 for 1 cycle after the 3rd tuple of a W=4, H=4, P=1 scan; then a new START with W=1, H=1, P=1.
- Response: no SEND or DONE in the reset cycle; outputs at reset values.
- Response: the new scan emits only (0,0,0), then DONE; TOKENS=1.
REQ-035: Plane wrap.
- Stimulus: W=1, H=2, P=3; all RDY=1.
- Response: sequence (0,0,0), (0,1,0), (0,0,1), (0,1,1), (0,0,2), (0,1,2); TOKENS=6.
